// File: rtl/char_motion_ctrl.sv
// char_motion_ctrl
//   Moves a game character on a pixel grid once per game tick. A free-running
//   divider produces an update edge every TICK_DIV+1 sys_clk cycles. On each
//   update the column moves left/right by one pixel and the row follows a
//   small GROUND / RISE / FALL jump state machine. Y grows downward.
//
// Ports
//   sys_clk    in   single clock
//   rst        in   synchronous active-high reset
//   mov[3:0]   in   keypad {up, down, left, right}; down is ignored
//   blk_left   in   cell left of the character is solid
//   blk_right  in   cell right of the character is solid
//   blk_above  in   cell above the character is solid
//   blk_below  in   cell below the character is solid
//   char_X     out  registered character column (0..X_MAX)
//   char_Y     out  registered character row (0..GROUND_Y)
//   state      out  0 GROUND, 1 RISE, 2 FALL
//   tick       out  one-cycle pulse in the cycle after each update
module char_motion_ctrl #(
  parameter int         TICK_DIV = 499999,
  parameter logic [9:0] X_MAX    = 10'd480,
  parameter logic [9:0] X_INIT   = 10'd1,
  parameter logic [9:0] GROUND_Y = 10'd400,
  parameter logic [9:0] JUMP_H   = 10'd48
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [3:0] mov,
  input  logic       blk_left,
  input  logic       blk_right,
  input  logic       blk_above,
  input  logic       blk_below,
  output logic [9:0] char_X,
  output logic [9:0] char_Y,
  output logic [1:0] state,
  output logic       tick
);

  localparam logic [1:0] ST_GROUND = 2'd0;
  localparam logic [1:0] ST_RISE   = 2'd1;
  localparam logic [1:0] ST_FALL   = 2'd2;

  // A zero divider still needs a one-bit counter.
  localparam int            CW      = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV);

  logic [CW-1:0] cnt;
  logic [9:0]    rise_cnt;
  logic          update;
  logic          left_only;
  logic          right_only;
  logic [9:0]    x_nxt;
  logic [9:0]    y_nxt;
  logic [1:0]    state_nxt;
  logic [9:0]    rise_nxt;

  // The down key has no function in this game.
  logic unused_down;
  assign unused_down = mov[2];

  assign update     = (cnt == CNT_MAX);
  assign left_only  = mov[1] & ~mov[0];
  assign right_only = mov[0] & ~mov[1];

  // Next position and jump state, used only on update edges. Horizontal and
  // vertical moves are independent and both read the current registers.
  always_comb begin
    x_nxt     = char_X;
    y_nxt     = char_Y;
    state_nxt = state;
    rise_nxt  = rise_cnt;

    if (left_only && (char_X != 10'd0) && !blk_left) begin
      x_nxt = char_X - 10'd1;
    end else if (right_only && (char_X < X_MAX) && !blk_right) begin
      x_nxt = char_X + 10'd1;
    end

    case (state)
      ST_GROUND: begin
        // Walking off a ledge takes priority over starting a jump.
        if (!blk_below && (char_Y < GROUND_Y)) begin
          state_nxt = ST_FALL;
          y_nxt     = char_Y + 10'd1;
        end else if (mov[3]) begin
          state_nxt = ST_RISE;
          rise_nxt  = 10'd0;
        end
      end
      ST_RISE: begin
        // The up key is not consulted here, so a jump always runs its course.
        if (blk_above || (char_Y == 10'd0) || (rise_cnt == JUMP_H)) begin
          state_nxt = ST_FALL;
        end else begin
          y_nxt    = char_Y - 10'd1;
          rise_nxt = rise_cnt + 10'd1;
        end
      end
      ST_FALL: begin
        // >= guards against ever moving below the floor row.
        if (blk_below || (char_Y >= GROUND_Y)) begin
          state_nxt = ST_GROUND;
        end else begin
          y_nxt = char_Y + 10'd1;
        end
      end
      default: begin
        state_nxt = ST_FALL;
      end
    endcase
  end

  // Divider, tick pulse and position registers. Reset wins over an update
  // that happens to fall on the same edge.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt      <= '0;
      char_X   <= X_INIT;
      char_Y   <= GROUND_Y;
      state    <= ST_GROUND;
      rise_cnt <= 10'd0;
      tick     <= 1'b0;
    end else begin
      tick <= update;
      if (update) begin
        cnt      <= '0;
        char_X   <= x_nxt;
        char_Y   <= y_nxt;
        state    <= state_nxt;
        rise_cnt <= rise_nxt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_char_motion_ctrl.sv
// tb_char_motion_ctrl
//   Directed bench for char_motion_ctrl with a short tick period (4 cycles),
//   a 3-pixel jump, floor row 10 and rightmost column 5. Each vector is held
//   through one game tick and the position/state seen after the tick pulse is
//   compared against hand-computed values.
module tb_char_motion_ctrl;

  localparam int         TICK_DIV = 3;
  localparam logic [9:0] X_MAX    = 10'd5;
  localparam logic [9:0] X_INIT   = 10'd1;
  localparam logic [9:0] GROUND_Y = 10'd10;
  localparam logic [9:0] JUMP_H   = 10'd3;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [3:0] mov;
  logic       blk_left;
  logic       blk_right;
  logic       blk_above;
  logic       blk_below;
  logic [9:0] char_X;
  logic [9:0] char_Y;
  logic [1:0] state;
  logic       tick;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [3:0] m;
    logic       bl;
    logic       br;
    logic       ba;
    logic       bb;
    logic [1:0] st;
    logic [9:0] x;
    logic [9:0] y;
  } vec_t;

  vec_t vecs[$];

  char_motion_ctrl #(
    .TICK_DIV (TICK_DIV),
    .X_MAX    (X_MAX),
    .X_INIT   (X_INIT),
    .GROUND_Y (GROUND_Y),
    .JUMP_H   (JUMP_H)
  ) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .mov       (mov),
    .blk_left  (blk_left),
    .blk_right (blk_right),
    .blk_above (blk_above),
    .blk_below (blk_below),
    .char_X    (char_X),
    .char_Y    (char_Y),
    .state     (state),
    .tick      (tick)
  );

  always #5 sys_clk = ~sys_clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] m, input logic bl, input logic br,
                               input logic ba, input logic bb);
    mov       = m;
    blk_left  = bl;
    blk_right = br;
    blk_above = ba;
    blk_below = bb;
  endtask

  // Waits (bounded) for the next tick pulse, sampling on falling edges.
  task automatic waitTick(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      if (tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_tick"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic addVec(input logic [3:0] m, input logic bl, input logic br,
                        input logic ba, input logic bb, input int st,
                        input int x, input int y);
    vec_t v;
    v.m  = m;
    v.bl = bl;
    v.br = br;
    v.ba = ba;
    v.bb = bb;
    v.st = 2'(st);
    v.x  = 10'(x);
    v.y  = 10'(y);
    vecs.push_back(v);
  endtask

  initial begin
    int tick_count;
    int first_tick;

    // Expected {state, X, Y} after each successive game tick.
    //     mov      bl br ba bb  st  x   y
    addVec(4'b0010, 0, 0, 0, 0,  0, 0, 10);
    addVec(4'b0010, 0, 0, 0, 0,  0, 0, 10);
    addVec(4'b0010, 0, 0, 0, 0,  0, 0, 10);
    addVec(4'b0011, 0, 0, 0, 0,  0, 0, 10);
    addVec(4'b0001, 0, 0, 0, 0,  0, 1, 10);
    addVec(4'b0001, 0, 0, 0, 0,  0, 2, 10);
    addVec(4'b0001, 0, 0, 0, 0,  0, 3, 10);
    addVec(4'b0001, 0, 0, 0, 0,  0, 4, 10);
    addVec(4'b0001, 0, 0, 0, 0,  0, 5, 10);
    addVec(4'b0001, 0, 0, 0, 0,  0, 5, 10);
    addVec(4'b0011, 0, 0, 0, 0,  0, 5, 10);
    addVec(4'b0010, 0, 0, 0, 0,  0, 4, 10);
    addVec(4'b0010, 0, 0, 0, 0,  0, 3, 10);
    addVec(4'b0010, 0, 0, 0, 0,  0, 2, 10);
    addVec(4'b0001, 0, 1, 0, 0,  0, 2, 10);
    addVec(4'b0010, 1, 0, 0, 0,  0, 2, 10);
    addVec(4'b0011, 0, 0, 0, 0,  0, 2, 10);
    // Full jump with one step right on take-off.
    addVec(4'b1001, 0, 0, 0, 0,  1, 3, 10);
    addVec(4'b0000, 0, 0, 0, 0,  1, 3, 9);
    addVec(4'b0000, 0, 0, 0, 0,  1, 3, 8);
    addVec(4'b0000, 0, 0, 0, 0,  1, 3, 7);
    addVec(4'b0000, 0, 0, 0, 0,  2, 3, 7);
    addVec(4'b0000, 0, 0, 0, 0,  2, 3, 8);
    addVec(4'b0000, 0, 0, 0, 0,  2, 3, 9);
    addVec(4'b0000, 0, 0, 0, 0,  2, 3, 10);
    addVec(4'b0000, 0, 0, 0, 0,  0, 3, 10);
    addVec(4'b0000, 0, 0, 0, 0,  0, 3, 10);
    // Land on a platform at row 7, head bump at row 6, then walk off a ledge.
    addVec(4'b1000, 0, 0, 0, 0,  1, 3, 10);
    addVec(4'b0000, 0, 0, 0, 0,  1, 3, 9);
    addVec(4'b0000, 0, 0, 0, 0,  1, 3, 8);
    addVec(4'b0000, 0, 0, 0, 0,  1, 3, 7);
    addVec(4'b0000, 0, 0, 0, 0,  2, 3, 7);
    addVec(4'b0000, 0, 0, 0, 1,  0, 3, 7);
    addVec(4'b1000, 0, 0, 0, 1,  1, 3, 7);
    addVec(4'b0000, 0, 0, 0, 1,  1, 3, 6);
    addVec(4'b0000, 0, 0, 1, 0,  2, 3, 6);
    addVec(4'b0000, 0, 0, 0, 1,  0, 3, 6);
    addVec(4'b1000, 0, 0, 0, 0,  2, 3, 7);
    addVec(4'b1000, 0, 0, 0, 0,  2, 3, 8);
    addVec(4'b1000, 0, 0, 0, 0,  2, 3, 9);
    addVec(4'b1000, 0, 0, 0, 0,  2, 3, 10);
    addVec(4'b1000, 0, 0, 0, 0,  0, 3, 10);
    addVec(4'b1000, 0, 0, 0, 0,  1, 3, 10);
    addVec(4'b0000, 0, 0, 0, 0,  1, 3, 9);
    addVec(4'b0000, 0, 0, 0, 0,  1, 3, 8);

    rst = 1'b1;
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    checkOutput("reset_pos", {10'd0, state, char_X, char_Y}, {10'd0, 2'd0, X_INIT, GROUND_Y});
    checkOutput("reset_tick", {31'd0, tick}, 32'd0);
    rst = 1'b0;

    tick_count = 0;
    first_tick = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge sys_clk);
      if (tick === 1'b1) begin
        tick_count++;
        if (first_tick == 0) first_tick = c;
      end
      checkOutput($sformatf("idle%0d", c), {10'd0, state, char_X, char_Y},
                  {10'd0, 2'd0, 10'd1, 10'd10});
    end
    checkOutput("idle_tick_count", tick_count, 32'd5);
    checkOutput("idle_first_tick", first_tick, 32'd4);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].m, vecs[i].bl, vecs[i].br, vecs[i].ba, vecs[i].bb);
      waitTick($sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d", i), {10'd0, state, char_X, char_Y},
                  {10'd0, vecs[i].st, vecs[i].x, vecs[i].y});
    end

    // One-cycle reset in the middle of a jump (row 8, rising).
    rst = 1'b1;
    @(negedge sys_clk);
    checkOutput("midjump_reset_pos", {10'd0, state, char_X, char_Y},
                {10'd0, 2'd0, 10'd1, 10'd10});
    checkOutput("midjump_reset_tick", {31'd0, tick}, 32'd0);
    rst = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge sys_clk);
      checkOutput($sformatf("post_reset_tick%0d", c), {31'd0, tick}, (c == 4) ? 32'd1 : 32'd0);
    end
    checkOutput("post_reset_pos", {10'd0, state, char_X, char_Y},
                {10'd0, 2'd0, 10'd1, 10'd10});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
